// File: rtl/debouncer_pkg.sv
// debouncer_pkg: shared FSM state encoding and glitch-counter constants for the debouncer.
package debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam int               GLITCH_W   = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_SAT = {GLITCH_W{1'b1}};

endpackage

// File: rtl/debouncer_sync_ff.sv
// sync_ff: SYNC_STAGES-deep flop chain bringing an asynchronous level into the clk domain.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_sync <= '0;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/debouncer.sv
// debouncer: accepts a new din level only after it holds STABLE_CYCLES synchronized cycles.
// Optional saturating rejected-transition counter glitch_cnt under DEBOUNCER_GLITCH_CNT_EN.
module debouncer
    import debouncer_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
`ifdef DEBOUNCER_GLITCH_CNT_EN
    output logic [GLITCH_W-1:0] glitch_cnt,
`endif
    output logic dout
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             w_din_sync;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .resetn(resetn),
        .i_d   (din),
        .o_q   (w_din_sync)
    );

    // counter only ever holds 1..STABLE_CYCLES-1 inside a WAIT, so it cannot wrap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE_LOW: if (w_din_sync) begin
                    r_state <= WAIT_HIGH;
                    r_cnt   <= CNT_ONE;
                end
                WAIT_HIGH: if (!w_din_sync) begin
                    r_state <= IDLE_LOW;
                    r_cnt   <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_state <= IDLE_HIGH;
                    r_cnt   <= '0;
                    r_dout  <= 1'b1;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
                IDLE_HIGH: if (!w_din_sync) begin
                    r_state <= WAIT_LOW;
                    r_cnt   <= CNT_ONE;
                end
                WAIT_LOW: if (w_din_sync) begin
                    r_state <= IDLE_HIGH;
                    r_cnt   <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_state <= IDLE_LOW;
                    r_cnt   <= '0;
                    r_dout  <= 1'b0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
                default: begin
                    r_state <= IDLE_LOW;
                    r_cnt   <= '0;
                    r_dout  <= 1'b0;
                end
            endcase
        end
    end

    assign dout = r_dout;

`ifdef DEBOUNCER_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] r_glitch_cnt;
    logic                w_reject;

    assign w_reject = (r_state == WAIT_HIGH || r_state == WAIT_LOW) && (w_din_sync == r_dout);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_glitch_cnt <= '0;
        else if (w_reject && r_glitch_cnt != GLITCH_SAT)
            r_glitch_cnt <= r_glitch_cnt + 1'b1;
    end

    assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning number of synchronizer flops on din (legal 2..4).
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive synchronized cycles of a new level needed to accept it (legal 2..255).
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port din  input  1  raw asynchronous level input (switch or pad).
REQ-006 SHALL have port dout  output  1  debounced level, registered, for a downstream edge detector.
REQ-007 SHALL have port glitch_cnt  output  8  count of rejected transitions (present only under DEBOUNCER_GLITCH_CNT_EN).

Function
REQ-008 SHALL pass din through a SYNC_STAGES-deep flop chain; its last stage is din_sync.
REQ-009 SHALL implement a 4-state FSM: IDLE_LOW (dout=0), WAIT_HIGH (dout=0), IDLE_HIGH (dout=1), WAIT_LOW (dout=1).
REQ-010 SHALL move IDLE_LOW->WAIT_HIGH when din_sync=1, and IDLE_HIGH->WAIT_LOW when din_sync=0, with the stability counter loaded to 1.
REQ-011 SHALL, in a WAIT state, increment the counter each cycle din_sync still differs from dout.
REQ-012 SHALL, when the counter equals STABLE_CYCLES-1 and din_sync still differs, toggle dout and enter the opposite IDLE state with the counter cleared, in the same edge.
REQ-013 SHALL, in a WAIT state, return to the matching IDLE state with the counter cleared, without changing dout, on any cycle din_sync equals dout (glitch rejected).
REQ-014 SHALL give a latency of exactly SYNC_STAGES+STABLE_CYCLES rising edges from the first edge sampling a new, held din level to the edge updating dout (6 at default values).
REQ-015 SHALL never change dout for a din pulse shorter than STABLE_CYCLES cycles once synchronized.
REQ-016 SHALL keep the counter ceil(log2(STABLE_CYCLES+1)) bits wide with no wrap-around reachable.
REQ-017 SHALL drive dout directly from a flop (no combinational path from din).

Reset
REQ-018 SHALL, on resetn low, asynchronously clear the sync chain, counter, glitch_cnt and dout to 0 and force IDLE_LOW.
REQ-019 SHALL abort any WAIT in progress on reset assertion mid-operation; nothing pending survives.
REQ-020 SHALL, after resetn deassertion with din held 1, raise dout after exactly SYNC_STAGES+STABLE_CYCLES edges.

Configuration
REQ-021 SHALL, with DEBOUNCER_GLITCH_CNT_EN defined, provide glitch_cnt, incremented by 1 on every REQ-013 rejection, saturating at 255.
REQ-022 SHALL, without DEBOUNCER_GLITCH_CNT_EN, omit the glitch_cnt port and its register entirely; all other behaviour identical.

Structure
REQ-023 SHALL place the FSM state typedef (IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW), the glitch counter width (8) and its saturation value in package debouncer_pkg.
REQ-024 SHALL implement the synchronizer chain as sub-module sync_ff, parameterized by SYNC_STAGES, reset by the same asynchronous resetn.

Verification
REQ-025 SHALL cover clean rise: reset, din=1 held from edge 1 -> dout=1 at edge 6, glitch_cnt=0.
REQ-026 SHALL cover short glitch: from IDLE_LOW, din=1 for 3 cycles then 0 -> dout stays 0, glitch_cnt=1.
REQ-027 SHALL cover bounce then settle: din toggles 1,0,1,0 one cycle each, then 1 held -> dout rises once, 6 edges after the final rise; glitch_cnt=2.
REQ-028 SHALL cover clean fall: from IDLE_HIGH, din=0 held -> dout=0 after 6 edges, no intermediate dout toggle.
REQ-029 SHALL cover reset mid-WAIT: din=1 for 4 cycles, resetn low asynchronously -> dout=0, state IDLE_LOW immediately; after release with din=1 held, dout=1 after 6 edges.
REQ-030 SHALL cover saturation: 300 rejected 2-cycle pulses -> glitch_cnt=255, dout=0 throughout.
